// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared defaults, count width helper and op encoding for the operand stack
package stack_pkg;

    localparam int STACK_WIDTH = 8;
    localparam int STACK_DEPTH = 16;

    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef logic [$clog2(STACK_DEPTH + 1)-1:0] count_t;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_REPL
    } stack_op_e;

endpackage

// File: rtl/stack_ram.sv
// rtl/stack_ram.sv - DEPTH x WIDTH register array, one sync write port, one async read port
module stack_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stack_unit.sv
// rtl/stack_unit.sv - operand stack with registered top-of-stack, depth and sticky error flags
module stack_unit
    import stack_pkg::*;
#(
    parameter int WIDTH = STACK_WIDTH,
    parameter int DEPTH = STACK_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic                        pop,
    input  logic [WIDTH-1:0]            din,
    input  logic                        err_clr,
    output logic [WIDTH-1:0]            tos,
    output logic [count_w(DEPTH)-1:0]   count,
    output logic                        empty,
    output logic                        full,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int CW = count_w(DEPTH);
    localparam int AW = $clog2(DEPTH);

    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] tos_q, tos_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    stack_op_e        op;
    logic             set_ovf, set_unf;
    logic             empty_w, full_w;
    logic [AW-1:0]    ptr, wr_addr, rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             ram_we;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CW'(DEPTH));

    always_comb begin
        op      = OP_NONE;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        case ({push, pop})
            2'b10: if (full_w) set_ovf = 1'b1; else op = OP_PUSH;
            2'b01: if (empty_w) set_unf = 1'b1; else op = OP_POP;
            2'b11: begin
                if (empty_w) begin
                    op      = OP_PUSH;
                    set_unf = 1'b1;
                end else begin
                    op = OP_REPL;
                end
            end
            default: ;
        endcase
    end

    // Modular pointer math: when full and DEPTH is a power of two, ptr wraps to 0
    // and ptr-1 / ptr-2 still land on the top two slots.
    assign ptr     = count_q[AW-1:0];
    assign wr_addr = (op == OP_REPL) ? ptr - AW'(1) : ptr;
    assign rd_addr = ptr - AW'(2);
    assign ram_we  = (op == OP_PUSH) || (op == OP_REPL);

    stack_ram #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_ram (
        .clk    (clk),
        .we     (ram_we),
        .wr_addr(wr_addr),
        .wr_data(din),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    always_comb begin
        count_d = count_q;
        tos_d   = tos_q;
        case (op)
            OP_PUSH: begin
                count_d = count_q + CW'(1);
                tos_d   = din;
            end
            OP_REPL: tos_d = din;
            OP_POP: begin
                count_d = count_q - CW'(1);
                tos_d   = (count_q == CW'(1)) ? '0 : rd_data;
            end
            default: ;
        endcase
        overflow_d  = (overflow_q  & ~err_clr) | set_ovf;
        underflow_d = (underflow_q & ~err_clr) | set_unf;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q     <= '0;
            tos_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            tos_q       <= tos_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign tos       = tos_q;
    assign count     = count_q;
    assign empty     = empty_w;
    assign full      = full_w;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_stack_unit.sv
// tb/tb_stack_unit.sv - scoreboard bench for stack_unit against a queue-based stack model
module tb_stack_unit;

    localparam int W = 8;
    localparam int D = 16;

    logic         clk;
    logic         rst;
    logic         push;
    logic         pop;
    logic [W-1:0] din;
    logic         err_clr;
    logic [W-1:0] tos;
    logic [4:0]   count;
    logic         empty;
    logic         full;
    logic         overflow;
    logic         underflow;

    stack_unit #(.WIDTH(W), .DEPTH(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .din      (din),
        .err_clr  (err_clr),
        .tos      (tos),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .overflow (overflow),
        .underflow(underflow)
    );

    typedef struct {
        int tos;
        int cnt;
        bit ovf;
        bit unf;
    } exp_t;

    exp_t     exp_q[$];
    bit [7:0] stk[$];
    bit       m_ovf;
    bit       m_unf;
    int       n_checks;
    int       n_pass;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e.tos = (stk.size() > 0) ? int'(stk[stk.size()-1]) : 0;
        e.cnt = stk.size();
        e.ovf = m_ovf;
        e.unf = m_unf;
        return e;
    endfunction

    // Monitor: one expectation per rising edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("tos",       int'(tos),       e.tos);
                chk("count",     int'(count),     e.cnt);
                chk("empty",     int'(empty),     int'(e.cnt == 0));
                chk("full",      int'(full),      int'(e.cnt == D));
                chk("overflow",  int'(overflow),  int'(e.ovf));
                chk("underflow", int'(underflow), int'(e.unf));
            end
        end
    end

    task automatic step(input bit p, input bit q, input bit [7:0] d, input bit c);
        bit rej_push;
        bit rej_pop;
        push    = p;
        pop     = q;
        din     = d;
        err_clr = c;
        rej_push = p && !q && (stk.size() == D);
        rej_pop  = q && (stk.size() == 0);
        if (c) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (rej_push) m_ovf = 1'b1;
        if (rej_pop)  m_unf = 1'b1;
        if (p && q && stk.size() > 0) stk[stk.size()-1] = d;
        else if (p && stk.size() < D) stk.push_back(d);
        else if (q && !p && stk.size() > 0) void'(stk.pop_back());
        exp_q.push_back(snapshot());
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        push    = 1'b1;
        pop     = 1'b0;
        din     = 8'hEE;
        err_clr = 1'b0;
        stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        exp_q.push_back(snapshot());
        @(negedge clk);
        rst  = 1'b1;
        push = 1'b0;
    endtask

    initial begin
        int mode;
        int r;
        n_checks = 0;
        n_pass   = 0;
        do_reset();

        // Reset mid-sequence, then first push after release
        step(1, 0, 8'h44, 0);
        step(1, 0, 8'h55, 0);
        step(0, 1, 8'h00, 0);
        do_reset();
        step(1, 0, 8'h11, 0);
        step(0, 1, 8'h00, 0);

        // LIFO order
        step(1, 0, 8'h05, 0);
        step(1, 0, 8'h0A, 0);
        step(1, 0, 8'h3C, 0);
        step(0, 1, 8'h00, 0);
        step(0, 1, 8'h00, 0);
        step(0, 1, 8'h00, 0);

        // Replace top
        step(1, 0, 8'h05, 0);
        step(1, 0, 8'h0A, 0);
        step(1, 1, 8'h0F, 0);
        step(0, 1, 8'h00, 0);
        step(0, 1, 8'h00, 0);

        // Fill, overflow, replace while full
        for (int i = 1; i <= D; i++) step(1, 0, 8'(i), 0);
        step(1, 0, 8'hFF, 0);
        step(1, 1, 8'hFF, 0);
        step(0, 1, 8'h00, 0);
        step(1, 0, 8'h77, 0);
        do_reset();

        // Underflow, clear, set-wins-over-clear, push+pop on empty
        step(0, 1, 8'h00, 0);
        step(0, 0, 8'h00, 1);
        step(0, 1, 8'h00, 1);
        step(0, 0, 8'h00, 1);
        step(1, 1, 8'h21, 0);
        step(0, 1, 8'h00, 1);

        // Controller ADD sequence
        step(1, 0, 8'h02, 0);
        step(1, 0, 8'h03, 0);
        step(0, 1, 8'h00, 0);
        step(0, 1, 8'h00, 0);
        step(1, 0, 8'h05, 0);
        step(0, 0, 8'h00, 0);

        // Random phases alternating fill and drain bias
        mode = 0;
        for (int n = 0; n < 800; n++) begin
            if (n % 60 == 0) mode = $urandom_range(0, 2);
            r = $urandom_range(0, 99);
            if (r == 0) begin
                do_reset();
            end else begin
                bit p, q, c;
                case (mode)
                    0: begin p = ($urandom_range(0, 99) < 75); q = ($urandom_range(0, 99) < 25); end
                    1: begin p = ($urandom_range(0, 99) < 25); q = ($urandom_range(0, 99) < 75); end
                    default: begin p = $urandom_range(0, 1) == 1; q = $urandom_range(0, 1) == 1; end
                endcase
                c = ($urandom_range(0, 99) < 6);
                step(p, q, 8'($urandom), c);
            end
        end

        step(0, 0, 8'h00, 0);
        @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
